led_blink_scheduler: RTL and testbench
======================================

Name: led_blink_scheduler

Overview:
- Shares one physical status LED among NUM_SRC asynchronous event sources.
- Each event is synchronized, edge-detected and latched as pending.
- A round-robin scheduler serves pending sources one at a time. It shows each served source as a blink code of (index+1) pulses, followed by an inter-code gap.
- Sits at the top level between fast debug/status strobes and the board LED pin, so a human can see which subsystem fired.

Parameters:
- NUM_SRC, 4, number of event sources (2..16).
- TICK_CYCLES, 1_250_000, clk cycles per time tick (>=2).
- ON_TICKS, 2, ticks the LED is lit per blink (>=1).
- OFF_TICKS, 2, ticks dark between blinks of one code (>=1).
- GAP_TICKS, 8, ticks dark after a complete code (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- event_i  in  NUM_SRC  asynchronous event strobes; a rising edge is an event.
- enable_i  in  1  scheduler enable; low forces the LED off.
- led_o  out  1  LED drive, active-high.
- busy_o  out  1  high while a code or gap is in progress.
- active_src_o  out  $clog2(NUM_SRC)  index of the source being shown (valid while busy_o is high).
- pending_o  out  NUM_SRC  latched, unserved events.

Behaviour:
- Reset value of every output is 0. Reset also clears the synchronizer flops, edge registers, pending flags, RR pointer, tick counter and blink counter. Reset applied mid-code aborts it immediately.
- Input path, per bit: 2-flop synchronizer, then an edge register. An event edge sets pending[i] 3 clk cycles after it appears at event_i.
- Pending: set on a detected edge, cleared when the source is granted. If set and clear coincide, set wins and the event stays queued. Repeated edges while already pending merge into one.
- Tick counter: counts 0..TICK_CYCLES-1, restarts at 0 on every state entry, and emits tick_done on the last count. A state with N ticks therefore lasts exactly N*TICK_CYCLES cycles.
- FSM states are IDLE, GRANT, ON, OFF, GAP.
- IDLE: led_o=0, busy_o=0. Goes to GRANT when enable_i is high and pending != 0.
- GRANT: one cycle. The RR picker selects the first pending index at or after ptr, wrapping modulo NUM_SRC. It latches active_src_o, clears that pending bit, sets ptr to winner+1 (mod NUM_SRC) and loads blink_cnt=winner+1. busy_o goes to 1. Next state is ON.
- ON: led_o=1. After ON_TICKS ticks it decrements blink_cnt. If the result is 0 it goes to GAP, otherwise to OFF.
- OFF: led_o=0. After OFF_TICKS ticks it goes back to ON.
- GAP: led_o=0. After GAP_TICKS ticks it goes to GRANT if enable_i is high and pending != 0, otherwise to IDLE.
- Latency: a pending bit seen in IDLE gives GRANT on the next cycle and led_o=1 on the cycle after that.
- enable_i low in any state: next cycle the FSM is in IDLE with led_o=0 and busy_o=0. Pending bits are retained and edges keep being captured. The interrupted source is not re-queued.
- Registered outputs: led_o and busy_o come from the state register.

Decomposition:
- Package led_sched_pkg holds the state enum (IDLE, GRANT, ON, OFF, GAP) and a helper function for the index width, $clog2 with a minimum of 1.
- One sub-module, rr_pick. It is combinational: inputs req[NUM_SRC] and ptr; outputs gnt_idx and gnt_valid; it does a rotate-priority search.
- Synchronizer and edge-detect stay inline as a generate loop.

Test Plan (TICK_CYCLES=4, ON=1, OFF=1, GAP=2, NUM_SRC=4):
- Single event on bit 2 from IDLE -> pending_o=4'b0100 three cycles later; GRANT; three 4-cycle LED pulses separated by 4-cycle dark gaps; active_src_o=2; 8-cycle gap; back to IDLE with pending_o=0.
- Events on bits 0 and 3 in the same cycle, ptr=0 -> source 0 is served first (1 blink), then source 3 (4 blinks); ptr ends at 0.
- Event on bit 1 re-fires while source 1 is being shown -> pending_o[1] stays set; a second 2-blink code follows after the gap.
- 1-cycle glitch pulse and 10 back-to-back edges on bit 0 before its grant -> exactly one code is shown per grant.
- enable_i dropped during an ON state -> LED off and busy_o=0 next cycle; pending_o is kept; re-enabling starts GRANT with the next RR index.
- reset asserted mid-OFF -> all outputs are 0 next cycle; a new event afterwards is served starting from ptr=0.

Source files
------------

// File: rtl/led_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_sched_pkg
// Description : Shared types and helpers for the LED blink scheduler.
//               - led_state_e : scheduler FSM state encoding
//               - idx_width() : $clog2 with a floor of 1 bit
// Revision    : 1.0 - initial release
// ============================================================================
package led_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    ON    = 3'd2,
    OFF   = 3'd3,
    GAP   = 3'd4
  } led_state_e;

  // Width needed to hold values 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_blink_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotate-priority picker. Returns the first set
//               request at or after ptr, wrapping modulo NUM_SRC.
// Ports       : req       in  NUM_SRC  request vector
//               ptr       in  IDX_W    search start index (< NUM_SRC)
//               gnt_idx   out IDX_W    winning index (0 when none)
//               gnt_valid out 1        at least one request is set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import led_sched_pkg::*;
#(
  parameter  int NUM_SRC = 4,
  localparam int IDX_W   = idx_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  int w_idx;

  // Walk offsets from farthest to nearest so the candidate closest to ptr
  // is the last one written and therefore wins.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    w_idx     = 0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      w_idx = int'(ptr) + k;
      if (w_idx >= NUM_SRC) begin
        w_idx = w_idx - NUM_SRC;
      end
      if (req[w_idx]) begin
        gnt_idx   = IDX_W'(w_idx);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_blink_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : led_blink_scheduler
// Description : Shares one status LED among NUM_SRC asynchronous event
//               sources. Events are synchronized, edge-detected and latched
//               as pending; a round-robin scheduler shows each served source
//               as (index+1) blinks followed by an inter-code gap.
// Ports       : clk          in  1        system clock
//               reset        in  1        synchronous active-high reset
//               event_i      in  NUM_SRC  async event strobes (rising edge)
//               enable_i     in  1        scheduler enable, low = LED off
//               led_o        out 1        LED drive, active-high
//               busy_o       out 1        code or gap in progress
//               active_src_o out IDX_W    source being shown
//               pending_o    out NUM_SRC  latched, unserved events
// Revision    : 1.0 - initial release
// ============================================================================
module led_blink_scheduler
  import led_sched_pkg::*;
#(
  parameter  int NUM_SRC     = 4,
  parameter  int TICK_CYCLES = 1_250_000,
  parameter  int ON_TICKS    = 2,
  parameter  int OFF_TICKS   = 2,
  parameter  int GAP_TICKS   = 8,
  localparam int IDX_W       = idx_width(NUM_SRC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] event_i,
  input  logic               enable_i,
  output logic               led_o,
  output logic               busy_o,
  output logic [IDX_W-1:0]   active_src_o,
  output logic [NUM_SRC-1:0] pending_o
);

  localparam int c_TICK_W    = idx_width(TICK_CYCLES);
  localparam int c_MAX_TICKS = (ON_TICKS > OFF_TICKS)
                             ? ((ON_TICKS  > GAP_TICKS) ? ON_TICKS  : GAP_TICKS)
                             : ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
  localparam int c_TNUM_W    = idx_width(c_MAX_TICKS);
  localparam int c_BLINK_W   = idx_width(NUM_SRC + 1);

  localparam logic [c_TICK_W-1:0]  c_TICK_LAST = c_TICK_W'(TICK_CYCLES - 1);
  localparam logic [c_TNUM_W-1:0]  c_ON_LAST   = c_TNUM_W'(ON_TICKS - 1);
  localparam logic [c_TNUM_W-1:0]  c_OFF_LAST  = c_TNUM_W'(OFF_TICKS - 1);
  localparam logic [c_TNUM_W-1:0]  c_GAP_LAST  = c_TNUM_W'(GAP_TICKS - 1);
  localparam logic [IDX_W-1:0]     c_LAST_IDX  = IDX_W'(NUM_SRC - 1);
  localparam logic [c_BLINK_W-1:0] c_BLINK_ONE = c_BLINK_W'(1);

  led_state_e             r_state;
  led_state_e             w_state_next;

  logic [NUM_SRC-1:0]     w_edge;
  logic [NUM_SRC-1:0]     w_clr;
  logic [NUM_SRC-1:0]     r_pending;
  logic [IDX_W-1:0]       r_ptr;
  logic [IDX_W-1:0]       r_active_src;
  logic [c_BLINK_W-1:0]   r_blink_cnt;
  logic [c_TICK_W-1:0]    r_tick_cnt;
  logic [c_TNUM_W-1:0]    r_tick_num;
  logic [c_TNUM_W-1:0]    w_ticks_last;
  logic                   w_tick_done;
  logic                   w_state_last_tick;
  logic [IDX_W-1:0]       w_gnt_idx;
  logic                   w_gnt_valid;
  logic                   w_grant_fire;
  logic                   w_any_pending;

  // --------------------------------------------------------------------------
  // Input path: 2-flop synchronizer, then a delayed copy for rising-edge detect
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_sync
    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
        r_prev  <= 1'b0;
      end else begin
        r_sync1 <= event_i[gi];
        r_sync2 <= r_sync1;
        r_prev  <= r_sync2;
      end
    end

    assign w_edge[gi] = r_sync2 & ~r_prev;
  end

  // --------------------------------------------------------------------------
  // Round-robin pick over the pending set
  // --------------------------------------------------------------------------
  rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_rr_pick (
    .req       (r_pending),
    .ptr       (r_ptr),
    .gnt_idx   (w_gnt_idx),
    .gnt_valid (w_gnt_valid)
  );

  assign w_any_pending = |r_pending;
  // A grant is only taken while enabled, so a disable during GRANT does not
  // silently drop the chosen event.
  assign w_grant_fire  = (r_state == GRANT) && enable_i && w_gnt_valid;

  always_comb begin
    w_clr = '0;
    if (w_grant_fire) begin
      w_clr[w_gnt_idx] = 1'b1;
    end
  end

  // Set has priority over clear so an edge arriving on the grant cycle stays
  // queued; repeated edges simply re-set an already set bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_edge;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr        <= '0;
      r_active_src <= '0;
      r_blink_cnt  <= '0;
    end else if (w_grant_fire) begin
      r_active_src <= w_gnt_idx;
      r_ptr        <= (w_gnt_idx == c_LAST_IDX) ? '0 : w_gnt_idx + IDX_W'(1);
      r_blink_cnt  <= c_BLINK_W'(w_gnt_idx) + c_BLINK_ONE;
    end else if ((r_state == ON) && w_state_last_tick) begin
      r_blink_cnt  <= r_blink_cnt - c_BLINK_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Tick timing: r_tick_cnt divides clk into ticks, r_tick_num counts ticks
  // spent in the current state. Both restart whenever the state changes.
  // --------------------------------------------------------------------------
  assign w_tick_done = (r_tick_cnt == c_TICK_LAST);

  always_comb begin
    w_ticks_last = '0;
    case (r_state)
      ON:      w_ticks_last = c_ON_LAST;
      OFF:     w_ticks_last = c_OFF_LAST;
      GAP:     w_ticks_last = c_GAP_LAST;
      default: w_ticks_last = '0;
    endcase
  end

  assign w_state_last_tick = w_tick_done && (r_tick_num == w_ticks_last);

  always_ff @(posedge clk) begin
    if (reset || (w_state_next != r_state)) begin
      r_tick_cnt <= '0;
      r_tick_num <= '0;
    end else if (w_tick_done) begin
      r_tick_cnt <= '0;
      r_tick_num <= r_tick_num + c_TNUM_W'(1);
    end else begin
      r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    if (!enable_i) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_any_pending) w_state_next = GRANT;
        GRANT:   w_state_next = w_gnt_valid ? ON : IDLE;
        ON:      if (w_state_last_tick)
                   w_state_next = (r_blink_cnt == c_BLINK_ONE) ? GAP : OFF;
        OFF:     if (w_state_last_tick) w_state_next = ON;
        GAP:     if (w_state_last_tick)
                   w_state_next = w_any_pending ? GRANT : IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs, decoded from the state register only
  // --------------------------------------------------------------------------
  always_comb begin
    led_o  = (r_state == ON);
    busy_o = (r_state != IDLE);
  end

  assign active_src_o = r_active_src;
  assign pending_o    = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_led_blink_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_blink_scheduler
// Description : Directed self-checking bench for led_blink_scheduler with
//               TICK_CYCLES=4, ON=1, OFF=1, GAP=2, NUM_SRC=4. A code for a
//               source with n blinks spans 8n+4 cycles after GRANT: ON
//               blocks of 4 cycles every 8 cycles, then an 8-cycle gap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_blink_scheduler;

  logic       clk;
  logic       reset;
  logic [3:0] event_i;
  logic       enable_i;
  logic       led_o;
  logic       busy_o;
  logic [1:0] active_src_o;
  logic [3:0] pending_o;

  int checks = 0;
  int errors = 0;

  led_blink_scheduler #(
    .NUM_SRC     (4),
    .TICK_CYCLES (4),
    .ON_TICKS    (1),
    .OFF_TICKS   (1),
    .GAP_TICKS   (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .event_i      (event_i),
    .enable_i     (enable_i),
    .led_o        (led_o),
    .busy_o       (busy_o),
    .active_src_o (active_src_o),
    .pending_o    (pending_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(input int budget);
    int k = 0;
    while (busy_o !== 1'b1 && k < budget) begin
      step(1);
      k++;
    end
    chk("grant_wait_busy", busy_o, 1);
    chk("grant_wait_led", led_o, 0);
  endtask

  // Called on the GRANT cycle; walks the whole code through the last gap
  // cycle. Optionally pulses event_i with fire_mask for one cycle after
  // cycle fire_at.
  task automatic check_code(input int src, input int n, input int fire_at,
                            input logic [3:0] fire_mask);
    logic exp_led;
    for (int i = 1; i <= 8 * n + 4; i++) begin
      step(1);
      exp_led = (((i - 1) % 8) < 4) && (((i - 1) / 8) < n);
      chk($sformatf("code%0d_led_c%0d", src, i), led_o, exp_led);
      chk($sformatf("code%0d_busy_c%0d", src, i), busy_o, 1);
      if (i == 1) chk($sformatf("code%0d_src", src), active_src_o, src);
      event_i = (i == fire_at) ? fire_mask : 4'b0000;
    end
  endtask

  initial begin
    reset    = 1'b1;
    event_i  = 4'b0000;
    enable_i = 1'b1;
    step(2);
    chk("rst_led", led_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_src", active_src_o, 0);
    chk("rst_pending", pending_o, 0);

    // 1) single event on bit 2, exact latency and 3-blink code
    reset   = 1'b0;
    event_i = 4'b0100;
    step(1);
    event_i = 4'b0000;
    chk("t1_pend_c1", pending_o, 4'b0000);
    step(1);
    chk("t1_pend_c2", pending_o, 4'b0000);
    step(1);
    chk("t1_pend_c3", pending_o, 4'b0100);
    chk("t1_idle_busy", busy_o, 0);
    step(1);
    chk("t1_grant_busy", busy_o, 1);
    chk("t1_grant_led", led_o, 0);
    check_code(2, 3, 0, 4'b0000);
    step(1);
    chk("t1_end_busy", busy_o, 0);
    chk("t1_end_pending", pending_o, 4'b0000);

    // 2) bits 0 and 3 together from ptr=0: source 0 then source 3
    reset = 1'b1;
    step(1);
    reset   = 1'b0;
    event_i = 4'b1001;
    step(1);
    event_i = 4'b0000;
    wait_grant(20);
    check_code(0, 1, 0, 4'b0000);
    step(1);
    chk("t2_regrant_busy", busy_o, 1);
    chk("t2_regrant_led", led_o, 0);
    check_code(3, 4, 0, 4'b0000);
    step(1);
    chk("t2_end_busy", busy_o, 0);
    chk("t2_end_pending", pending_o, 4'b0000);

    // 3) bit 1 re-fires while source 1 is shown
    event_i = 4'b0010;
    step(1);
    event_i = 4'b0000;
    wait_grant(20);
    check_code(1, 2, 2, 4'b0010);
    chk("t3_requeued", pending_o, 4'b0010);
    step(1);
    chk("t3_regrant_busy", busy_o, 1);
    check_code(1, 2, 0, 4'b0000);
    step(1);
    chk("t3_end_busy", busy_o, 0);
    chk("t3_end_pending", pending_o, 4'b0000);

    // 4) glitch plus 10 edges on bit 0 while disabled merge into one code
    enable_i = 1'b0;
    event_i  = 4'b0001;
    step(1);
    event_i = 4'b0000;
    step(3);
    for (int e = 0; e < 10; e++) begin
      event_i = 4'b0001;
      step(1);
      event_i = 4'b0000;
      step(1);
    end
    step(4);
    chk("t4_merged_pending", pending_o, 4'b0001);
    chk("t4_disabled_busy", busy_o, 0);
    enable_i = 1'b1;
    wait_grant(5);
    check_code(0, 1, 0, 4'b0000);
    step(1);
    chk("t4_end_busy", busy_o, 0);
    chk("t4_end_pending", pending_o, 4'b0000);

    // 5) disable during ON; ptr=1 so source 2 first, then source 3
    event_i = 4'b1100;
    step(1);
    event_i = 4'b0000;
    wait_grant(20);
    step(1);
    chk("t5_on_led", led_o, 1);
    chk("t5_on_src", active_src_o, 2);
    enable_i = 1'b0;
    step(1);
    chk("t5_dis_led", led_o, 0);
    chk("t5_dis_busy", busy_o, 0);
    chk("t5_dis_pending", pending_o, 4'b1000);
    enable_i = 1'b1;
    step(1);
    chk("t5_reen_busy", busy_o, 1);
    chk("t5_reen_led", led_o, 0);
    check_code(3, 4, 0, 4'b0000);
    step(1);
    chk("t5_end_busy", busy_o, 0);
    chk("t5_end_pending", pending_o, 4'b0000);

    // 6) reset mid-OFF, then service restarts from ptr=0
    event_i = 4'b0010;
    step(1);
    event_i = 4'b0000;
    wait_grant(20);
    step(1);
    chk("t6_on_led", led_o, 1);
    event_i = 4'b1000;
    step(1);
    event_i = 4'b0000;
    step(3);
    chk("t6_off_led", led_o, 0);
    chk("t6_off_busy", busy_o, 1);
    chk("t6_off_pending", pending_o, 4'b1000);
    reset = 1'b1;
    step(1);
    chk("t6_rst_led", led_o, 0);
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_src", active_src_o, 0);
    chk("t6_rst_pending", pending_o, 4'b0000);
    reset   = 1'b0;
    event_i = 4'b0101;
    step(1);
    event_i = 4'b0000;
    wait_grant(20);
    check_code(0, 1, 0, 4'b0000);
    step(1);
    chk("t6_regrant_busy", busy_o, 1);
    check_code(2, 3, 0, 4'b0000);
    step(1);
    chk("t6_end_busy", busy_o, 0);
    chk("t6_end_pending", pending_o, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
